// File: rtl/ark_pkg.sv
// Shared constants and types for the AES AddRoundKey pipeline.
// Holds block/tag widths, the slot-count limit and the slot payload type.
package ark_pkg;

    localparam int AES_BLOCK_W       = 128;
    localparam int ARK_TAG_W_DEFAULT = 4;
    localparam int ARK_MAX_STAGES    = 4;

    // One slot's worth of payload at the default widths: tag above state.
    typedef struct packed {
        logic [ARK_TAG_W_DEFAULT-1:0] tag;
        logic [AES_BLOCK_W-1:0]       state;
    } ark_slot_t;

    // True when a slot count can be built.
    function automatic bit ark_stages_ok(input int stages);
        return (stages >= 1) && (stages <= ARK_MAX_STAGES);
    endfunction

endpackage

// File: rtl/ark_pipe_slot.sv
// One elastic register slot: valid bit plus payload.
// Loads whenever it is empty or its own contents leave this cycle.
module ark_pipe_slot
    import ark_pkg::*;
#(
    parameter int W = ARK_TAG_W_DEFAULT + AES_BLOCK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         adv;

    // Advance when empty or draining; payload only changes on a real load.
    always_comb begin
        adv     = !valid_q || dn_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    // Slot state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign up_ready = adv;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/add_round_key_pipe.sv
// Elastic AddRoundKey stage: state ^ key (or bypass) into a chain of
// STAGES valid/ready register slots, with the round tag carried along.
module add_round_key_pipe
    import ark_pkg::*;
#(
    parameter int DATA_W = AES_BLOCK_W,
    parameter int STAGES = 1,
    parameter int TAG_W  = ARK_TAG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [DATA_W-1:0] in_key,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              in_bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_state,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int PW = TAG_W + DATA_W;

    if (!ark_stages_ok(STAGES)) begin : g_bad_stages
        $error("add_round_key_pipe: STAGES out of range");
    end

    if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_width
        $error("add_round_key_pipe: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mix_state;
    logic [PW-1:0]     mix_payload;

    logic [STAGES:0]   stage_valid;
    logic [PW-1:0]     stage_data [STAGES+1];

    // Round-key XOR, with bypass selected ahead of slot 0.
    always_comb begin
        mix_state   = in_bypass ? in_state : (in_state ^ in_key);
        mix_payload = {in_tag, mix_state};
    end

    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = mix_payload;

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        logic rdy_in;
        logic rdy_out;

        if (i == STAGES - 1) begin : g_last
            assign rdy_in = out_ready;
        end else begin : g_mid
            assign rdy_in = g_slot[i+1].rdy_out;
        end

        ark_pipe_slot #(
            .W(PW)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .up_valid(stage_valid[i]),
            .up_ready(rdy_out),
            .up_data (stage_data[i]),
            .dn_valid(stage_valid[i+1]),
            .dn_ready(rdy_in),
            .dn_data (stage_data[i+1])
        );
    end

    assign in_ready  = g_slot[0].rdy_out;
    assign out_valid = stage_valid[STAGES];
    assign out_state = stage_data[STAGES][DATA_W-1:0];
    assign out_tag   = stage_data[STAGES][PW-1:DATA_W];
    assign busy      = |stage_valid[STAGES:1];

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Directed bench for add_round_key_pipe.
// One instance per slot count 1..4, driven from a single stimulus thread.
module tb_add_round_key_pipe;
    import ark_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [1:4];
    logic         ir   [1:4];
    logic [127:0] ist  [1:4];
    logic [127:0] iky  [1:4];
    logic [3:0]   itg  [1:4];
    logic         ib   [1:4];
    logic         ov   [1:4];
    logic         ordy [1:4];
    logic [127:0] ost  [1:4];
    logic [3:0]   otg  [1:4];
    logic         bz   [1:4];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 1; k <= 4; k++) begin : g_dut
        add_round_key_pipe #(
            .DATA_W(128),
            .STAGES(k),
            .TAG_W (4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[k]),
            .in_ready (ir[k]),
            .in_state (ist[k]),
            .in_key   (iky[k]),
            .in_tag   (itg[k]),
            .in_bypass(ib[k]),
            .out_valid(ov[k]),
            .out_ready(ordy[k]),
            .out_state(ost[k]),
            .out_tag  (otg[k]),
            .busy     (bz[k])
        );
    end

    task automatic chk(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] mk_state(input logic [3:0] t);
        return {4{32'h3c5a_9617}} ^ {32{t}};
    endfunction

    function automatic logic [127:0] mk_key(input logic [3:0] t);
        return {16{t, 4'he}};
    endfunction

    task automatic drive(input int k, input logic v, input logic [3:0] t);
        iv[k]  = v;
        ist[k] = mk_state(t);
        iky[k] = mk_key(t);
        itg[k] = t;
    endtask

    logic [127:0] tp_st [64];
    logic [127:0] tp_ky [64];
    logic [3:0]   tp_tg [64];
    ark_slot_t    exp_s;

    initial begin
        int t;
        int acc;
        int nxt;

        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            iv[k] = 1'b0; ist[k] = '0; iky[k] = '0;
            itg[k] = '0; ib[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            chk("rst_out_valid", ov[k], 1'b0);
            chk("rst_out_state", ost[k], 128'h0);
            chk("rst_out_tag", otg[k], 4'h0);
            chk("rst_busy", bz[k], 1'b0);
            chk("rst_in_ready", ir[k], 1'b1);
        end

        // FIPS-197 App. B round 0, one slot.
        next_cycle();
        iv[1]  = 1'b1;
        ist[1] = 128'h3243f6a8885a308d313198a2e0370734;
        iky[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        itg[1] = 4'h0;
        next_cycle();
        iv[1] = 1'b0;
        @(negedge clk);
        chk("fips_valid", ov[1], 1'b1);
        chk("fips_state", ost[1], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("fips_tag", otg[1], 4'h0);

        // Bypass passes state through untouched.
        next_cycle();
        iv[1]  = 1'b1;
        ib[1]  = 1'b1;
        ist[1] = 128'h00112233445566778899aabbccddeeff;
        iky[1] = {128{1'b1}};
        itg[1] = 4'ha;
        next_cycle();
        iv[1] = 1'b0;
        ib[1] = 1'b0;
        @(negedge clk);
        chk("byp_valid", ov[1], 1'b1);
        chk("byp_state", ost[1], 128'h00112233445566778899aabbccddeeff);
        chk("byp_tag", otg[1], 4'ha);

        // Backpressure, three slots: fill with out_ready low.
        ordy[3] = 1'b0;
        t = 1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            drive(3, t <= 5, t[3:0]);
            @(negedge clk);
            if (ov[3]) begin
                chk("bp_stall_state", ost[3], mk_state(1) ^ mk_key(1));
                chk("bp_stall_tag", otg[3], 4'h1);
            end
            if (iv[3] && ir[3]) begin
                acc++;
                t++;
            end
        end
        chk("bp_accepted", acc, 3);
        chk("bp_in_ready_low", ir[3], 1'b0);
        chk("bp_busy", bz[3], 1'b1);

        // Release: ready propagates back at once, tags drain in order.
        nxt = 1;
        for (int c = 0; c < 16; c++) begin
            next_cycle();
            ordy[3] = 1'b1;
            drive(3, t <= 5, t[3:0]);
            @(negedge clk);
            if (c == 0) chk("bp_ready_rise", ir[3], 1'b1);
            if (ov[3]) begin
                chk("bp_order_tag", otg[3], nxt[3:0]);
                chk("bp_order_state", ost[3],
                    mk_state(nxt[3:0]) ^ mk_key(nxt[3:0]));
                nxt++;
            end
            if (iv[3] && ir[3]) t++;
        end
        chk("bp_all_sent", t, 6);
        chk("bp_all_out", nxt, 6);
        iv[3] = 1'b0;

        // Full throughput, four slots, 64 random transfers.
        for (int j = 0; j < 64; j++) begin
            tp_st[j] = {$urandom, $urandom, $urandom, $urandom};
            tp_ky[j] = {$urandom, $urandom, $urandom, $urandom};
            tp_tg[j] = 4'($urandom_range(0, 15));
        end
        ordy[4] = 1'b1;
        for (int c = 0; c < 70; c++) begin
            next_cycle();
            if (c < 64) begin
                iv[4]  = 1'b1;
                ist[4] = tp_st[c];
                iky[4] = tp_ky[c];
                itg[4] = tp_tg[c];
            end else begin
                iv[4] = 1'b0;
            end
            @(negedge clk);
            if (c < 64) chk("tp_in_ready", ir[4], 1'b1);
            chk("tp_out_valid", ov[4], (c >= 4) && (c < 68));
            if ((c >= 4) && (c < 68)) begin
                exp_s.tag   = tp_tg[c-4];
                exp_s.state = tp_st[c-4] ^ tp_ky[c-4];
                chk("tp_data", {otg[4], ost[4]}, exp_s);
            end
        end

        // Bubble collapse, two slots.
        ordy[2] = 1'b0;
        next_cycle();
        drive(2, 1'b1, 4'h7);
        @(negedge clk);
        chk("bub_first_ready", ir[2], 1'b1);
        next_cycle();
        iv[2] = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("bub_slot1_valid", ov[2], 1'b1);
        chk("bub_slot1_tag", otg[2], 4'h7);
        chk("bub_hole_ready", ir[2], 1'b1);
        next_cycle();
        drive(2, 1'b1, 4'h8);
        @(negedge clk);
        chk("bub_accept_ready", ir[2], 1'b1);
        next_cycle();
        drive(2, 1'b1, 4'h9);
        @(negedge clk);
        chk("bub_full_ready", ir[2], 1'b0);
        chk("bub_full_tag", otg[2], 4'h7);
        next_cycle();
        iv[2] = 1'b0;
        ordy[2] = 1'b1;
        @(negedge clk);
        chk("bub_drain0_tag", otg[2], 4'h7);
        next_cycle();
        @(negedge clk);
        chk("bub_drain1_valid", ov[2], 1'b1);
        chk("bub_drain1_tag", otg[2], 4'h8);
        chk("bub_drain1_state", ost[2], mk_state(8) ^ mk_key(8));
        next_cycle();
        @(negedge clk);
        chk("bub_empty", ov[2], 1'b0);

        // Reset mid-stream, three slots with three in flight.
        ordy[3] = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            next_cycle();
            drive(3, 1'b1, 4'(j));
            @(negedge clk);
            chk("mr_fill_ready", ir[3], 1'b1);
        end
        next_cycle();
        rst = 1'b1;
        drive(3, 1'b1, 4'h4);
        @(negedge clk);
        chk("mr_busy_before", bz[3], 1'b1);
        next_cycle();
        rst = 1'b0;
        iv[3] = 1'b0;
        ordy[3] = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", ov[3], 1'b0);
        chk("mr_busy", bz[3], 1'b0);
        chk("mr_out_state", ost[3], 128'h0);
        chk("mr_out_tag", otg[3], 4'h0);
        chk("mr_in_ready", ir[3], 1'b1);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            chk("mr_no_stale", ov[3], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/add_round_key_pipe.md
# add_round_key_pipe

Parametrised, elastic AddRoundKey stage for the AES datapath. It XORs a state block with a round key and carries a round tag alongside the data. The result passes through a configurable number of register slots with valid/ready flow control, so the round loop can absorb backpressure from downstream consumers. It replaces the fixed single-register AddRoundKey and adds a per-transfer bypass mode for the final-round and debug paths.

## Interface
Parameters:
- DATA_W, 128: state/key width in bits; any multiple of 8 ≥ 8.
- STAGES, 1: number of register slots, legal range 1–4.
- TAG_W, 4: sideband round-tag width.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  slot 0 can accept a transfer.
- in_state  input  DATA_W  state block (post-MixColumns or plaintext).
- in_key  input  DATA_W  round key for this transfer.
- in_tag  input  TAG_W  round number or tag, passed through unmodified.
- in_bypass  input  1  1 = pass in_state without XOR.
- out_valid  output  1  last slot holds a result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  DATA_W  result of in_state ^ in_key, or in_state when bypass is set.
- out_tag  output  TAG_W  tag accompanying out_state.
- busy  output  1  OR of all slot valid bits.

## Operation
- A transfer occurs on any edge where valid and ready are both high at the respective side.
- The XOR is computed combinationally from the in_* signals and captured into slot 0. Slots 1..STAGES-1 are plain register copies. The bypass select is applied before slot 0.
- Each slot i holds v[i], data[i] and tag[i].
- Slot i advances (loads from slot i-1, or from the inputs for i=0) when it is empty or when its own contents move on in the same cycle. Slot STAGES-1 moves on when out_valid && out_ready.
- in_ready = !v[0] || adv[0]. It is a combinational path from out_ready; this is accepted because STAGES ≤ 4.
- Bubbles collapse: an empty slot accepts a new transfer even while later slots are stalled.
- A slot that is not loading keeps its data and tag unchanged. Data does not change while v is high and the slot is stalled.
- A slot that is vacated with no incoming transfer clears v[i]. Its data register is left stale, and its contents are don't-care while v=0.
- Simultaneous accept and emit on the same slot in the same cycle is a legal full-throughput case. There is no dead cycle.
- Out-of-range STAGES values are a static elaboration error.

## Timing
- Reset (rst=1 at an edge): every v[i] = 0 and every data[i]/tag[i] = 0. As a result out_valid=0, out_state=0, out_tag=0, busy=0, and in_ready=1 in the cycle after reset.
- Reset mid-operation discards every in-flight transfer without emitting it. Inputs presented in the reset cycle are not captured.
- Latency: a transfer accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. it is visible in the cycle following that edge (STAGES=1: visible after edge N).
- Throughput: 1 transfer/cycle while out_ready=1.
- With out_ready held low, the block accepts exactly STAGES transfers, then in_ready=0.
- When out_ready rises, in_ready rises in the same cycle.
- Ordering is strict FIFO; tags never reorder relative to their data.

## Structure
- Shared package ark_pkg holds:
  - AES_BLOCK_W = 128
  - ARK_TAG_W_DEFAULT = 4
  - ARK_MAX_STAGES = 4
  - a typedef for the {tag, state} slot payload
- One sub-module, ark_pipe_slot: a single valid/data/tag register with advance logic. It is instantiated STAGES times in a generate loop. The XOR/bypass mux stays in the top level.

## Test plan
- FIPS-197 App. B round 0, STAGES=1, in_bypass=0: in_state=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, tag=0 -> next cycle out_state=193de3bea0f4e22b9ac68d2ae9f84808, out_tag=0.
- Bypass: in_state=00112233445566778899aabbccddeeff, key=all-ones, in_bypass=1, tag=A -> out_state=00112233445566778899aabbccddeeff, out_tag=A.
- Backpressure, STAGES=3: out_ready=0, stream tags 1..5.
  - Expected: exactly 3 accepted, then in_ready=0, busy=1.
  - Then raise out_ready: tags emerge as 1,2,3,4,5 in order, with no drops or duplicates, and output data is stable during the stall.
- Full throughput, STAGES=4: 64 random back-to-back transfers with out_ready=1 -> first out_valid 4 cycles after first accept, then 64 consecutive results matching the XOR model.
- Bubble collapse, STAGES=2: fill slot 1 only, hold out_ready=0, offer a transfer -> it is accepted into slot 0 (in_ready=1), then in_ready=0.
- Reset mid-stream, STAGES=3: assert rst with 3 in flight -> next cycle out_valid=0, busy=0, out_state=0, in_ready=1, and no stale result is emitted afterwards.
